// File: rtl/dac_pkg.sv
// Shared types and sizing for the threshold-DAC programming sequencer.
package dac_pkg;

  localparam int NUM_CH = 16;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STB_HI,
    VAL,
    STB_LO,
    REL,
    HOLD
  } state_t;

  typedef struct packed {
    logic       sgn;
    logic [4:0] mag;
  } dac_setting_t;

endpackage

// File: rtl/dac_cfg_table.sv
// Per-channel DAC setting register file: one write port, write-first combinational read.
module dac_cfg_table
  import dac_pkg::*;
#(
  parameter logic [4:0] DEF_MAG = 5'd3,
  parameter logic       DEF_SGN = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [CH_W-1:0]   i_waddr,
  input  dac_setting_t      i_wdata,
  input  logic [CH_W-1:0]   i_raddr,
  output dac_setting_t      o_rdata
);

  dac_setting_t w_entries [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_entry
    dac_setting_t r_entry;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_entry <= '{sgn: DEF_SGN, mag: DEF_MAG};
      end else if (i_we && (i_waddr == CH_W'(gi))) begin
        r_entry <= i_wdata;
      end
    end

    assign w_entries[gi] = r_entry;
  end

  // Bypass lets a write on the sampling edge land in the value being sampled.
  assign o_rdata = (i_we && (i_waddr == i_raddr)) ? i_wdata : w_entries[i_raddr];

endmodule

// File: rtl/dac_program_seq.sv
// Walks all channels through address/strobe/value/release bursts on the shared DAC bus,
// and lends the bus to a static external-address hold requester when idle.
module dac_program_seq
  import dac_pkg::*;
#(
  parameter int         PHASE_CYCLES = 10,
  parameter logic [4:0] DEF_MAG      = 5'd3,
  parameter logic       DEF_SGN      = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_addr,
  input  logic [4:0]      cfg_mag,
  input  logic            cfg_sgn,
  input  logic            hold_req,
  input  logic [4:0]      hold_addr,
  output logic            hold_gnt,
  output logic            busy,
  output logic            done,
  output logic            sel_ext_addr,
  output logic            dac_stb,
  output logic [4:0]      dac_data,
  output logic            dac_sgn
);

  localparam int PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_CYCLES - 1);

  state_t          r_state, w_state_next;
  logic [CH_W-1:0] r_ch, w_ch_next;
  logic [PH_W-1:0] r_phase, w_phase_next;
  logic            r_start_pend, w_start_pend_next;

  logic       r_sel, w_sel_next;
  logic       r_stb, w_stb_next;
  logic [4:0] r_data, w_data_next;
  logic       r_sgn, w_sgn_next;
  logic       r_busy, w_busy_next;
  logic       r_done, w_done_next;
  logic       r_gnt, w_gnt_next;

  dac_setting_t w_rd;
  logic         w_phase_end;

  dac_cfg_table #(
    .DEF_MAG (DEF_MAG),
    .DEF_SGN (DEF_SGN)
  ) u_table (
    .clk     (clk),
    .rst     (rst),
    .i_we    (cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata ('{sgn: cfg_sgn, mag: cfg_mag}),
    .i_raddr (r_ch),
    .o_rdata (w_rd)
  );

  assign w_phase_end = (r_phase == PH_LAST);

  always_comb begin
    w_state_next      = r_state;
    w_ch_next         = r_ch;
    w_phase_next      = r_phase + PH_W'(1);
    w_start_pend_next = r_start_pend | start;
    w_done_next       = 1'b0;

    case (r_state)
      IDLE: begin
        w_phase_next = '0;
        if (r_start_pend || start) begin
          w_state_next = ADDR;
          w_ch_next    = '0;
        end else if (hold_req) begin
          w_state_next = HOLD;
        end
      end
      ADDR, STB_HI, VAL, STB_LO: begin
        if (w_phase_end) begin
          w_phase_next = '0;
          w_state_next = state_t'(r_state + 3'd1);
        end
      end
      REL: begin
        if (w_phase_end) begin
          w_phase_next = '0;
          if (r_ch == CH_W'(NUM_CH - 1)) begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
          end else begin
            w_ch_next    = r_ch + CH_W'(1);
            w_state_next = ADDR;
          end
        end
      end
      HOLD: begin
        w_phase_next = '0;
        if (!hold_req) w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
        w_phase_next = '0;
      end
    endcase

    // Only IDLE can enter ADDR for channel 0, so that is where a pending start is consumed.
    if (r_state == IDLE && w_state_next == ADDR) w_start_pend_next = 1'b0;
  end

  always_comb begin
    w_sel_next  = 1'b0;
    w_stb_next  = 1'b0;
    w_data_next = '0;
    w_sgn_next  = 1'b0;
    w_busy_next = 1'b0;
    w_gnt_next  = 1'b0;

    case (w_state_next)
      ADDR, STB_HI: begin
        w_sel_next  = 1'b1;
        w_stb_next  = (w_state_next == STB_HI);
        w_data_next = 5'(w_ch_next);
        w_busy_next = 1'b1;
      end
      VAL, STB_LO, REL: begin
        // The setting is sampled once on entry to VAL and held through release.
        w_sel_next  = (w_state_next != REL);
        w_stb_next  = (w_state_next == VAL);
        w_data_next = (r_state == STB_HI) ? w_rd.mag : r_data;
        w_sgn_next  = (r_state == STB_HI) ? w_rd.sgn : r_sgn;
        w_busy_next = 1'b1;
      end
      HOLD: begin
        w_sel_next  = 1'b1;
        w_data_next = hold_addr;
        w_gnt_next  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ch         <= '0;
      r_phase      <= '0;
      r_start_pend <= 1'b0;
      r_sel        <= 1'b0;
      r_stb        <= 1'b0;
      r_data       <= '0;
      r_sgn        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_gnt        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ch         <= w_ch_next;
      r_phase      <= w_phase_next;
      r_start_pend <= w_start_pend_next;
      r_sel        <= w_sel_next;
      r_stb        <= w_stb_next;
      r_data       <= w_data_next;
      r_sgn        <= w_sgn_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_gnt        <= w_gnt_next;
    end
  end

  assign sel_ext_addr = r_sel;
  assign dac_stb      = r_stb;
  assign dac_data     = r_data;
  assign dac_sgn      = r_sgn;
  assign busy         = r_busy;
  assign done         = r_done;
  assign hold_gnt     = r_gnt;

endmodule
